store_stage_queue: RTL

- Ordered store staging FIFO between the memory-issue/commit stage and the write buffer's port-0 store interface.
- Accepts up to two committed stores per cycle (channel A older than channel B).
- Presents stores one at a time, oldest first, with a wr/ack handshake.
- Provides a load-address hit flag so loads to a line with a pending staged store are held off.

---
 rtl/store_stage_queue_if.sv | 54 +++++
 rtl/store_stage_queue.sv | 122 ++++++++++++
 2 files changed

// File: rtl/store_stage_queue_if.sv
// Port bundle for the store staging queue: two enqueue channels, the write-buffer
// presentation/ack handshake, the load-address probe and the status outputs.
interface store_stage_queue_if #(
  parameter int PW  = 3,
  parameter int QBW = 5,
  parameter int RBW = 5
);
  logic             a_wr_i;
  logic [QBW-1:0]   a_id_i;
  logic [RBW-1:0]   a_rid_i;
  logic             a_ol_i;
  logic [9:0]       a_sel_i;
  logic [79:0]      a_adr_i;
  logic [79:0]      a_dat_i;
  logic             a_rdy_o;
  logic             b_wr_i;
  logic [QBW-1:0]   b_id_i;
  logic [RBW-1:0]   b_rid_i;
  logic             b_ol_i;
  logic [9:0]       b_sel_i;
  logic [79:0]      b_adr_i;
  logic [79:0]      b_dat_i;
  logic             b_rdy_o;
  logic             flush_i;
  logic             hold_i;
  logic             wr_o;
  logic [QBW-1:0]   id_o;
  logic [RBW-1:0]   rid_o;
  logic             ol_o;
  logic [9:0]       sel_o;
  logic [79:0]      adr_o;
  logic [79:0]      dat_o;
  logic             ack_i;
  logic [79:0]      ld_adr_i;
  logic             ld_hit_o;
  logic [PW:0]      count_o;
  logic             empty_o;

  modport master (
    output a_wr_i, a_id_i, a_rid_i, a_ol_i, a_sel_i, a_adr_i, a_dat_i,
    output b_wr_i, b_id_i, b_rid_i, b_ol_i, b_sel_i, b_adr_i, b_dat_i,
    output flush_i, hold_i, ack_i, ld_adr_i,
    input  a_rdy_o, b_rdy_o, wr_o, id_o, rid_o, ol_o, sel_o, adr_o, dat_o,
    input  ld_hit_o, count_o, empty_o
  );

  modport slave (
    input  a_wr_i, a_id_i, a_rid_i, a_ol_i, a_sel_i, a_adr_i, a_dat_i,
    input  b_wr_i, b_id_i, b_rid_i, b_ol_i, b_sel_i, b_adr_i, b_dat_i,
    input  flush_i, hold_i, ack_i, ld_adr_i,
    output a_rdy_o, b_rdy_o, wr_o, id_o, rid_o, ol_o, sel_o, adr_o, dat_o,
    output ld_hit_o, count_o, empty_o
  );
endinterface

// File: rtl/store_stage_queue.sv
// Ordered store staging FIFO: up to two committed stores in per cycle, one out per
// wr/ack handshake, oldest first, with a 16-byte-line load hit probe.
module store_stage_queue #(
  parameter int DEPTH = 8,
  parameter int PW    = 3,
  parameter int QBW   = 5,
  parameter int RBW   = 5
) (
  input logic               clk_i,
  input logic               rst_i,
  store_stage_queue_if.slave bus
);
  localparam logic [PW:0]  LIMIT_ONE = (PW+1)'(DEPTH - 1);
  localparam logic [PW:0]  LIMIT_TWO = (PW+1)'(DEPTH - 2);
  localparam logic [79:0]  LINE_MASK = {76'hFFFF_FFFF_FFFF_FFFF_FFF, 4'h0};

  logic [DEPTH-1:0] valid;
  logic [QBW-1:0]   id_mem  [DEPTH];
  logic [RBW-1:0]   rid_mem [DEPTH];
  logic             ol_mem  [DEPTH];
  logic [9:0]       sel_mem [DEPTH];
  logic [79:0]      adr_mem [DEPTH];
  logic [79:0]      dat_mem [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic          a_acc;
  logic          b_acc;
  logic          deq;
  logic          wr;
  logic [PW-1:0] b_slot;
  logic [1:0]    enq_n;
  logic          hit;

  // Acceptance, dequeue and presentation decode from registered state.
  always_comb begin
    a_acc  = bus.a_wr_i & (count <= LIMIT_ONE);
    b_acc  = bus.b_wr_i & (count <= LIMIT_TWO);
    b_slot = a_acc ? (tail + PW'(1)) : tail;
    enq_n  = {1'b0, a_acc} + {1'b0, b_acc};
    wr     = valid[head] & ~bus.hold_i;
    deq    = bus.ack_i & wr;
  end

  // Line-granular match of the load probe against every staged store.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (((adr_mem[i] ^ bus.ld_adr_i) & LINE_MASK) == 80'h0)) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
  end

  // Output drive.
  always_comb begin
    bus.a_rdy_o  = count <= LIMIT_ONE;
    bus.b_rdy_o  = count <= LIMIT_TWO;
    bus.wr_o     = wr;
    bus.id_o     = id_mem[head];
    bus.rid_o    = rid_mem[head];
    bus.ol_o     = ol_mem[head];
    bus.sel_o    = sel_mem[head];
    bus.adr_o    = adr_mem[head];
    bus.dat_o    = dat_mem[head];
    bus.ld_hit_o = hit;
    bus.count_o  = count;
    bus.empty_o  = (count == (PW+1)'(0));
  end

  // Pointers, occupancy and valid bits; flush outranks enqueue and ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else if (bus.flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (deq) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      if (a_acc) begin
        valid[tail] <= 1'b1;
      end
      if (b_acc) begin
        valid[b_slot] <= 1'b1;
      end
      tail  <= tail + PW'(enq_n);
      count <= count + (PW+1)'(enq_n) - (PW+1)'(deq);
    end
  end

  // Payload storage is left unreset; only the valid bits qualify it.
  always_ff @(posedge clk_i) begin
    if (a_acc) begin
      id_mem[tail]  <= bus.a_id_i;
      rid_mem[tail] <= bus.a_rid_i;
      ol_mem[tail]  <= bus.a_ol_i;
      sel_mem[tail] <= bus.a_sel_i;
      adr_mem[tail] <= bus.a_adr_i;
      dat_mem[tail] <= bus.a_dat_i;
    end
    if (b_acc) begin
      id_mem[b_slot]  <= bus.b_id_i;
      rid_mem[b_slot] <= bus.b_rid_i;
      ol_mem[b_slot]  <= bus.b_ol_i;
      sel_mem[b_slot] <= bus.b_sel_i;
      adr_mem[b_slot] <= bus.b_adr_i;
      dat_mem[b_slot] <= bus.b_dat_i;
    end
  end
endmodule
